hex_display_scanner: RTL

//  Time-multiplexed driver for NUM_DIGITS hex digits sharing one 7-seg bus plus decimal point.

---
 rtl/hex_disp_pkg.sv | 18 +
 rtl/hex_seg_lut.sv | 11 +
 rtl/hex_display_scanner.sv | 117 +++++++++++
 3 files changed

// File: rtl/hex_disp_pkg.sv
// Shared definitions for the multiplexed hex display: segment LUT and polarity helper.
// Segment bit order is bit0=a .. bit6=g, patterns are active-high (1 = lit).
package hex_disp_pkg;

    localparam int SEG_BITS = 7;

    localparam logic [SEG_BITS-1:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Converts an active-high pattern into the board's pin polarity.
    function automatic logic [SEG_BITS-1:0] seg_polarity(input logic [SEG_BITS-1:0] pat,
                                                         input logic active_low);
        return active_low ? ~pat : pat;
    endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational nibble to 7-segment pattern decoder (active-high lit).
module hex_seg_lut
    import hex_disp_pkg::*;
(
    input  logic [3:0]          nibble,
    output logic [SEG_BITS-1:0] pattern
);

    assign pattern = SEG_LUT[nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display driver: scans NUM_DIGITS digits over one shared 7-seg bus,
// with a ghosting guard at each slot start, leading-zero blanking and frame-aligned updates.
module hex_display_scanner
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int GUARD      = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    output logic [SEG_BITS-1:0]     seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GUARD_P = PW'(GUARD);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic          POL     = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] EN_ONE = NUM_DIGITS'(1);

    logic [PW-1:0]             pre;
    logic [IW-1:0]             idx;
    logic [4*NUM_DIGITS-1:0]   pend_val, disp_val;
    logic [NUM_DIGITS-1:0]     pend_dp, disp_dp;
    logic                      pend_valid;

    logic                      slot_wrap, frame_wrap;
    logic [3:0]                cur_nib;
    logic [SEG_BITS-1:0]       cur_pat;
    logic [NUM_DIGITS-1:0]     lz_blank;
    logic                      zero_run;
    logic [SEG_BITS-1:0]       seg_next;
    logic                      dp_next;
    logic [NUM_DIGITS-1:0]     en_next;

    assign slot_wrap  = (pre == PRE_MAX);
    assign frame_wrap = slot_wrap && (idx == IDX_MAX);

    always_comb begin
        cur_nib = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) cur_nib = disp_val[4*i +: 4];
        end
    end

    // A digit is blanked when it and every more-significant digit are zero; digit 0 never is.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS-1; i >= 1; i--) begin
            zero_run    = zero_run && (disp_val[4*i +: 4] == 4'h0);
            lz_blank[i] = blank_lz && zero_run;
        end
    end

    hex_seg_lut u_lut (
        .nibble  (cur_nib),
        .pattern (cur_pat)
    );

    always_comb begin
        seg_next = seg_polarity(lz_blank[idx] ? '0 : cur_pat, POL);
        dp_next  = disp_dp[idx] ^ POL;
        en_next  = (pre >= GUARD_P) ? (EN_ONE << idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre        <= '0;
            idx        <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
            seg        <= seg_polarity('0, POL);
            dp         <= POL;
            digit_en   <= '0;
            frame      <= 1'b0;
        end else begin
            seg      <= seg_next;
            dp       <= dp_next;
            digit_en <= en_next;
            frame    <= (pre == '0) && (idx == '0);

            pre <= slot_wrap ? '0 : pre + 1'b1;
            if (slot_wrap) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;

            // A load landing on the wrap bypasses pend so it shows in the frame now starting.
            if (frame_wrap) begin
                pend_valid <= 1'b0;
                if (load) begin
                    disp_val <= value;
                    disp_dp  <= dp_mask;
                end else if (pend_valid) begin
                    disp_val <= pend_val;
                    disp_dp  <= pend_dp;
                end
            end else if (load) begin
                pend_val   <= value;
                pend_dp    <= dp_mask;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule
